// File: rtl/mem_access_unit.sv
// MEM stage: drives load/store over a req/ack data bus, stalls upstream while busy,
// and registers the MEM/WB pipeline fields. Timeouts and misaligned accesses abort with bus_err.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Reg_Write_MEM,
    input  logic        memWrite_MEM,
    input  logic        memRead_MEM,
    input  logic        memToReg_MEM,
    input  logic        writePC_MEM,
    input  logic [4:0]  Write_Reg_MEM,
    input  logic [31:0] Read_Data2_MEM,
    input  logic [31:0] ALUout_MEM,
    input  logic [31:0] PC_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_MEM,
    output logic        bus_err,
    output logic        Reg_Write_WB,
    output logic        memToReg_WB,
    output logic        writePC_WB,
    output logic [4:0]  Write_Reg_WB,
    output logic [31:0] Read_Data_WB,
    output logic [31:0] ALUout_WB,
    output logic [31:0] PC_WB
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]   r_rdata, w_rdata_nxt;
    logic          r_err, w_err_nxt;
    logic          w_req_nxt, w_bus_err_nxt;

    logic w_access, w_misaligned, w_load, w_done_err, w_done_ok;

    assign w_access     = memRead_MEM | memWrite_MEM;
    assign w_misaligned = w_access & (ALUout_MEM[1:0] != 2'b00);
    assign w_load       = memRead_MEM & ~memWrite_MEM;
    assign w_done_err   = (r_state == DONE) & r_err;
    assign w_done_ok    = (r_state == DONE) & ~r_err;

    // Reset forces stall low so the upstream pipeline sees all-zero outputs while held.
    assign stall_MEM  = rst & (((r_state == IDLE) & w_access) | (r_state == WAIT));
    assign dmem_we    = dmem_req & memWrite_MEM;
    assign dmem_addr  = dmem_req ? ALUout_MEM : 32'h0;
    assign dmem_wdata = dmem_req ? Read_Data2_MEM : 32'h0;

    // Access sequencing: IDLE -> WAIT (or DONE when misaligned) -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_cnt_nxt   = '0;
                    w_rdata_nxt = 32'h0;
                    w_err_nxt   = w_misaligned;
                    w_state_nxt = w_misaligned ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    w_state_nxt = DONE;
                    w_err_nxt   = 1'b0;
                    w_rdata_nxt = w_load ? dmem_rdata : 32'h0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_req_nxt     = (w_state_nxt == WAIT);
        w_bus_err_nxt = (w_state_nxt == DONE) & w_err_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
            dmem_req <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rdata  <= w_rdata_nxt;
            r_err    <= w_err_nxt;
            dmem_req <= w_req_nxt;
            bus_err  <= w_bus_err_nxt;
        end
    end

    // MEM/WB register: bubble while stalled, error kills register/PC writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Reg_Write_WB <= 1'b0;
            memToReg_WB  <= 1'b0;
            writePC_WB   <= 1'b0;
            Write_Reg_WB <= 5'h0;
            Read_Data_WB <= 32'h0;
            ALUout_WB    <= 32'h0;
            PC_WB        <= 32'h0;
        end else if (stall_MEM) begin
            Reg_Write_WB <= 1'b0;
            memToReg_WB  <= 1'b0;
            writePC_WB   <= 1'b0;
            Write_Reg_WB <= 5'h0;
            Read_Data_WB <= 32'h0;
            ALUout_WB    <= 32'h0;
            PC_WB        <= 32'h0;
        end else begin
            Reg_Write_WB <= Reg_Write_MEM & ~w_done_err;
            memToReg_WB  <= memToReg_MEM;
            writePC_WB   <= writePC_MEM & ~w_done_err;
            Write_Reg_WB <= Write_Reg_MEM;
            Read_Data_WB <= w_done_ok ? r_rdata : 32'h0;
            ALUout_WB    <= ALUout_MEM;
            PC_WB        <= PC_MEM;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: random instruction stream, bus responder, retire monitor.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    typedef struct packed {
        logic        rw, mw, mr, m2r, wpc;
        logic [4:0]  wr;
        logic [31:0] d2, alu, pc;
        logic [7:0]  lat;   // WAIT cycle on which ack arrives; 0 = never
        logic [31:0] rdata;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Reg_Write_MEM = 0, memWrite_MEM = 0, memRead_MEM = 0, memToReg_MEM = 0, writePC_MEM = 0;
    logic [4:0]  Write_Reg_MEM = 0;
    logic [31:0] Read_Data2_MEM = 0, ALUout_MEM = 0, PC_MEM = 0;
    logic        dmem_req, dmem_we, dmem_ack = 0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
    logic        stall_MEM, bus_err;
    logic        Reg_Write_WB, memToReg_WB, writePC_WB;
    logic [4:0]  Write_Reg_WB;
    logic [31:0] Read_Data_WB, ALUout_WB, PC_WB;

    int     n_vec = 0;
    int     n_err = 0;
    instr_t exp_q[$];
    instr_t cur = '0;
    logic   mon_en = 1'b0;
    logic   prev_stall = 1'b1;
    int     reqc = 0, stc = 0, errc = 0, wait_cnt = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .Reg_Write_MEM(Reg_Write_MEM), .memWrite_MEM(memWrite_MEM), .memRead_MEM(memRead_MEM),
        .memToReg_MEM(memToReg_MEM), .writePC_MEM(writePC_MEM), .Write_Reg_MEM(Write_Reg_MEM),
        .Read_Data2_MEM(Read_Data2_MEM), .ALUout_MEM(ALUout_MEM), .PC_MEM(PC_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_MEM(stall_MEM), .bus_err(bus_err),
        .Reg_Write_WB(Reg_Write_WB), .memToReg_WB(memToReg_WB), .writePC_WB(writePC_WB),
        .Write_Reg_WB(Write_Reg_WB), .Read_Data_WB(Read_Data_WB), .ALUout_WB(ALUout_WB), .PC_WB(PC_WB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic instr_t mk(input logic rw, mw, mr, m2r, wpc, input logic [4:0] wr,
                                  input logic [31:0] d2, alu, pc, input logic [7:0] lat,
                                  input logic [31:0] rdata);
        instr_t t;
        t.rw = rw; t.mw = mw; t.mr = mr; t.m2r = m2r; t.wpc = wpc; t.wr = wr;
        t.d2 = d2; t.alu = alu; t.pc = pc; t.lat = lat; t.rdata = rdata;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        cur            = t;
        Reg_Write_MEM  = t.rw;
        memWrite_MEM   = t.mw;
        memRead_MEM    = t.mr;
        memToReg_MEM   = t.m2r;
        writePC_MEM    = t.wpc;
        Write_Reg_MEM  = t.wr;
        Read_Data2_MEM = t.d2;
        ALUout_MEM     = t.alu;
        PC_MEM         = t.pc;
    endtask

    // Upstream stage: present an instruction and hold it until the MEM stage stops stalling.
    task automatic issue(input instr_t t);
        logic done;
        done = 1'b0;
        drive(t);
        exp_q.push_back(t);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!stall_MEM) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Data-memory responder: acks on the planned WAIT cycle, injects stray acks while idle.
    always @(negedge clk) begin
        if (dmem_req) begin
            wait_cnt++;
            chk("bus_we", {31'd0, dmem_we}, {31'd0, cur.mw});
            chk("bus_addr", dmem_addr, cur.alu);
            chk("bus_wdata", dmem_wdata, cur.d2);
            dmem_ack   <= (cur.lat != 0) && (wait_cnt == int'(cur.lat));
            dmem_rdata <= (wait_cnt == int'(cur.lat)) ? cur.rdata : $urandom;
        end else begin
            wait_cnt = 0;
            chk("bus_idle", {dmem_we, dmem_addr | dmem_wdata}, 33'd0);
            dmem_ack   <= ($urandom_range(0, 3) == 0);
            dmem_rdata <= $urandom;
        end
    end

    // Retire monitor: instruction leaves MEM at an edge where stall was low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!prev_stall) begin
                if (exp_q.size() > 0) begin
                    instr_t t;
                    logic   acc, mis, err;
                    int     ereq, est;
                    t    = exp_q.pop_front();
                    acc  = t.mr | t.mw;
                    mis  = acc && (t.alu[1:0] != 2'b00);
                    err  = acc && (mis || t.lat == 0 || int'(t.lat) > int'(TO));
                    ereq = (!acc || mis) ? 0 : (err ? int'(TO) : int'(t.lat));
                    est  = !acc ? 0 : (mis ? 1 : ereq + 1);
                    chk("wb_ctrl", {24'd0, Reg_Write_WB, memToReg_WB, writePC_WB, Write_Reg_WB},
                        {24'd0, t.rw & ~err, t.m2r, t.wpc & ~err, t.wr});
                    chk("wb_rdata", Read_Data_WB, (acc && t.mr && !t.mw && !err) ? t.rdata : 32'h0);
                    chk("wb_alu", ALUout_WB, t.alu);
                    chk("wb_pc", PC_WB, t.pc);
                    chk("req_cycles", 32'(reqc), 32'(ereq));
                    chk("stall_cycles", 32'(stc), 32'(est));
                    chk("bus_err_pulses", 32'(errc), {31'd0, err});
                end
                reqc = 0;
                stc  = 0;
                errc = 0;
            end else begin
                chk("bubble_ctrl", {24'd0, Reg_Write_WB, memToReg_WB, writePC_WB, Write_Reg_WB}, 32'd0);
                chk("bubble_data", Read_Data_WB | ALUout_WB | PC_WB, 32'd0);
            end
            reqc += int'(dmem_req);
            stc  += int'(stall_MEM);
            errc += int'(bus_err);
            prev_stall = stall_MEM;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        logic   hit;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        chk("rst_wb", {Reg_Write_WB, memToReg_WB, writePC_WB, Write_Reg_WB} | 8'(Read_Data_WB | ALUout_WB | PC_WB), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        issue(mk(1, 0, 0, 0, 0, 5'd5, 32'h0, 32'h1234, 32'h40, 8'd0, 32'h0));
        issue(mk(1, 0, 1, 1, 0, 5'd7, 32'h0, 32'h100, 32'h44, 8'd3, 32'hDEADBEEF));
        issue(mk(0, 1, 0, 0, 0, 5'd0, 32'hCAFEF00D, 32'h200, 32'h48, 8'd1, 32'h0));
        issue(mk(1, 0, 1, 1, 1, 5'd9, 32'h0, 32'h300, 32'h4C, 8'd0, 32'h11111111));
        issue(mk(1, 0, 1, 1, 0, 5'd3, 32'h0, 32'h102, 32'h50, 8'd1, 32'h22222222));
        issue(mk(1, 0, 1, 1, 0, 5'd4, 32'h0, 32'h104, 32'h54, 8'(TO), 32'h33333333));

        for (int i = 0; i < 150; i++) begin
            t       = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
            t.mr    = ($urandom_range(0, 2) != 0) ? 1'b0 : t.mr;
            t.alu   = ($urandom_range(0, 7) == 0) ? t.alu : {t.alu[31:2], 2'b00};
            t.lat   = 8'($urandom_range(0, TO + 1));
            issue(t);
        end

        drive('0);
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;

        // Reset asserted in the middle of an outstanding load.
        drive(mk(1, 0, 1, 1, 1, 5'd6, 32'h0, 32'h400, 32'h60, 8'd0, 32'h0));
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dmem_req) begin
                hit = 1'b1;
                break;
            end
        end
        chk("pre_rst_req", {31'd0, hit}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall_MEM}, 32'd0);
        chk("midrst_err", {31'd0, bus_err}, 32'd0);
        chk("midrst_wb", {24'd0, Reg_Write_WB, memToReg_WB, writePC_WB, Write_Reg_WB}, 32'd0);
        chk("midrst_wbdata", Read_Data_WB | ALUout_WB | PC_WB, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_hold_stall", {31'd0, stall_MEM}, 32'd0);
        drive('0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_err", {31'd0, bus_err}, 32'd0);
        chk("post_rst_req", {31'd0, dmem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage consumer of the EX/MEM pipeline register: takes the MEM-side control and data fields, performs load/store through a req/ack data-memory bus, stalls the upstream pipeline while an access is outstanding, and registers the MEM/WB pipeline fields. Non-memory instructions pass through with zero added latency. Bus timeouts and misaligned addresses are aborted with a one-cycle error pulse, not hung.

## Interface
Parameters:
- TIMEOUT, 16: max WAIT cycles without ack before abort (≥2); counter width $clog2(TIMEOUT).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Reg_Write_MEM, memWrite_MEM, memRead_MEM, memToReg_MEM, writePC_MEM  in  1 each  EX/MEM control fields
- Write_Reg_MEM  in  5  destination register
- Read_Data2_MEM, ALUout_MEM, PC_MEM  in  32 each  store data, address/ALU result, PC
- dmem_req  out  1  bus request, high throughout WAIT
- dmem_we  out  1  1 = store; valid with dmem_req
- dmem_addr, dmem_wdata  out  32 each  = ALUout_MEM, Read_Data2_MEM while dmem_req
- dmem_ack  in  1  one-cycle completion strobe; sampled only in WAIT
- dmem_rdata  in  32  load data, valid with dmem_ack
- stall_MEM  out  1  hold EX/MEM and earlier stages (combinational)
- bus_err  out  1  one-cycle abort pulse
- Reg_Write_WB, memToReg_WB, writePC_WB  out  1 each  MEM/WB control
- Write_Reg_WB  out  5;  Read_Data_WB, ALUout_WB, PC_WB  out  32 each

## Operation
- access = memRead_MEM | memWrite_MEM; both high → store (dmem_we=1), load ignored.
- misaligned = access & (ALUout_MEM[1:0] != 0).
- FSM states IDLE, WAIT, DONE:
  - IDLE: access & !misaligned → WAIT, counter cleared; misaligned → DONE with err=1; else stay.
  - WAIT: dmem_ack → DONE, rdata captured, err=0; counter == TIMEOUT-1 without ack → DONE, err=1; else counter++.
  - DONE: → IDLE unconditionally.
- stall_MEM = (state==IDLE & access) | (state==WAIT).
- dmem_req = (state==WAIT); dmem_we = memWrite_MEM when req, else 0; addr/wdata driven 0 when req low.
- MEM/WB load when !stall_MEM: fields copied from the *_MEM inputs; Read_Data_WB = captured rdata (0 if no load or err).
- On err in DONE: Reg_Write_WB=0, writePC_WB=0, Read_Data_WB=0; bus_err=1 that cycle only. Store already on bus is not retracted.
- When stall_MEM=1: MEM/WB loads a bubble (all control bits 0, data fields 0).
- dmem_ack outside WAIT: ignored, no state change.

## Timing
- Reset (rst low, async): state=IDLE, counter=0, capture reg=0, all outputs 0; dmem_req drops immediately, including mid-WAIT; outstanding access abandoned, no bus_err.
- Non-memory instruction: stall_MEM=0, MEM/WB updated at next edge (1-cycle register latency).
- Memory access, ack in first WAIT cycle: cycle0 IDLE (stall=1), cycle1 WAIT (req=1, ack), cycle2 DONE (stall=0); MEM/WB valid after edge ending cycle2; EX/MEM advances at that same edge. Each extra ack-wait cycle adds one.
- Timeout: req high exactly TIMEOUT cycles, then DONE with bus_err.
- Misaligned: cycle0 IDLE stall, cycle1 DONE bus_err; dmem_req never asserted.
- Back-to-back memory instructions: DONE→IDLE gives no extra bubble beyond the FSM sequence; new access detected in the IDLE cycle after DONE.

## Test plan
- ALU op (memRead=memWrite=0, ALUout=0x1234, Reg_Write=1, Write_Reg=5) → stall_MEM=0, next edge ALUout_WB=0x1234, Write_Reg_WB=5, Reg_Write_WB=1, dmem_req=0.
- Load addr 0x100, ack after 3 WAIT cycles with rdata 0xDEADBEEF → req high 3 cycles, stall 4 cycles, Read_Data_WB=0xDEADBEEF, memToReg_WB=1; bubbles (Reg_Write_WB=0) during stall.
- Store addr 0x200, data 0xCAFEF00D, ack in first WAIT → dmem_we=1, addr/wdata match for 1 cycle, total stall 2 cycles, no bus_err.
- Load, no ack, TIMEOUT=4 → req high exactly 4 cycles, bus_err pulse 1 cycle, Reg_Write_WB=0, Read_Data_WB=0.
- Load addr 0x102 → no dmem_req, bus_err next cycle, Reg_Write_WB=0; then rst low mid-WAIT of a following load → req and stall drop same cycle, all WB outputs 0.
